// File: rtl/calc_seq_alu.sv
// calc_seq_alu: W-bit sequential ALU with a valid/ready handshake, shift-add multiply and,
// when macro CALC_DIV_EN is defined, a restoring unsigned divider (otherwise mode 111 flags err).
module calc_seq_alu #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   modo,
  output logic [W-1:0] c,
  output logic         ovf,
  output logic         zero,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);
  // Handshake: an operation transfers on a rising edge with in_valid && in_ready (IDLE only);
  // a result transfers on an edge with out_valid && out_ready (DONE only), so the two never overlap.
  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef CALC_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle result path, evaluated on the live inputs at the accepting edge.
  logic [W:0]   sum_w;
  logic [W:0]   dif_w;
  logic [W-1:0] sc_c;
  logic         sc_ovf;
  logic         sc_err;

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    dif_w  = {1'b0, a} - {1'b0, b};
    sc_c   = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    case (modo)
      3'b000: begin sc_c = dif_w[W-1:0]; sc_ovf = dif_w[W]; end
      3'b001: begin sc_c = sum_w[W-1:0]; sc_ovf = sum_w[W]; end
      3'b100: sc_c = a & b;
      3'b101: sc_c = a | b;
      3'b110: sc_c = a ^ b;
      3'b111: sc_err = 1'b1;
      default: ;
    endcase
  end

`ifdef CALC_DIV_EN
  logic [W-1:0] quo;
  logic [W-1:0] dvsr;
  logic [W-1:0] rem;
  logic [W-1:0] quo_nx;
  logic [W-1:0] rem_nx;
  logic [W:0]   rem_sh;
  logic [W:0]   trial;

  // One restoring step: shift the next dividend bit into the remainder, keep the
  // subtraction only when it does not borrow.
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    trial  = rem_sh - {1'b0, dvsr};
    if (trial[W]) begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo[W-2:0], 1'b0};
    end else begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo[W-2:0], 1'b1};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      c      <= '0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
`ifdef CALC_DIV_EN
      quo    <= '0;
      dvsr   <= '0;
      rem    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (modo == 3'b010) begin
              mcand  <= {{W{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end
`ifdef CALC_DIV_EN
            else if (modo == 3'b111) begin
              quo   <= a;
              dvsr  <= b;
              rem   <= '0;
              cnt   <= '0;
              state <= DIV;
            end
`endif
            else begin
              c     <= sc_c;
              ovf   <= sc_ovf;
              err   <= sc_err;
              zero  <= (sc_c == '0);
              state <= DONE;
            end
          end
        end
        MUL: begin
          // W shift-add steps, then one more edge to publish the product.
          if (cnt == CNT_LAST) begin
            c     <= acc[W-1:0];
            ovf   <= |acc[2*W-1:W];
            err   <= 1'b0;
            zero  <= (acc[W-1:0] == '0);
            state <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
`ifdef CALC_DIV_EN
        DIV: begin
          if (dvsr == '0) begin
            c     <= '1;
            ovf   <= 1'b1;
            err   <= 1'b0;
            zero  <= 1'b0;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            c     <= quo;
            ovf   <= 1'b0;
            err   <= 1'b0;
            zero  <= (quo == '0);
            state <= DONE;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_alu.sv
// tb_calc_seq_alu: directed and randomized checks of calc_seq_alu against a latency/arithmetic
// model; follows CALC_DIV_EN the same way as the design.
module tb_calc_seq_alu;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   modo = '0;
  logic [W-1:0] c;
  logic         ovf;
  logic         zero;
  logic         err;
  logic         out_valid;
  logic         out_ready = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  calc_seq_alu #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .modo      (modo),
    .c         (c),
    .ovf       (ovf),
    .zero      (zero),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result {err, ovf, c} and the number of extra edges after accept before DONE.
  task automatic ref_op(input int ra, input int rb, input int rm,
                        output logic [W+1:0] res, output int lat);
    int r;
    bit o;
    bit e;
    r = 0; o = 1'b0; e = 1'b0; lat = 0;
    case (rm)
      0: begin r = (ra - rb + MOD) % MOD; o = (ra < rb); end
      1: begin r = (ra + rb) % MOD; o = ((ra + rb) >= MOD); end
      2: begin r = (ra * rb) % MOD; o = ((ra * rb) >= MOD); lat = W + 1; end
      3: r = 0;
      4: r = ra & rb;
      5: r = ra | rb;
      6: r = ra ^ rb;
      default: begin
`ifdef CALC_DIV_EN
        if (rb == 0) begin r = MOD - 1; o = 1'b1; lat = 1; end
        else begin r = ra / rb; lat = W + 1; end
`else
        e = 1'b1;
`endif
      end
    endcase
    res = {e, o, r[W-1:0]};
  endtask

  // scoreboard
  logic [W+1:0] exp_q[$];
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_c    = '0;
  bit           m_ovf  = 1'b0;
  bit           m_zero = 1'b0;
  bit           m_err  = 1'b0;

  task automatic load_result();
    logic [W+1:0] res;
    chk("model_queue_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      res    = exp_q.pop_front();
      m_c    = res[W-1:0];
      m_ovf  = res[W];
      m_err  = res[W+1];
      m_zero = (res[W-1:0] == '0);
    end
    m_done = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [W+1:0] res;
    int           lat;
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_c = '0; m_ovf = 1'b0; m_zero = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) load_result();
    end else if (in_valid) begin
      ref_op(int'(a), int'(b), int'(modo), res, lat);
      exp_q.push_back(res);
      m_left = lat;
      if (lat == 0) load_result();
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  (!m_done && m_left == 0));
      chk("out_valid", out_valid, m_done);
      chk("c",         c,         m_c);
      chk("ovf",       ovf,       m_ovf);
      chk("zero",      zero,      m_zero);
      chk("err",       err,       m_err);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2:0] tm);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1) begin
      tick();
      guard++;
      if (guard > 50) begin
        chk("send_timeout", 0, 1);
        return;
      end
    end
    a = ta; b = tb_v; modo = tm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a    = W'($urandom);
    b    = W'($urandom);
    modo = 3'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_c", c, 0);
    chk("rst_flags", {ovf, zero, err, out_valid}, 0);
    chk("rst_in_ready", in_ready, 1);

    // subtract with borrow, result visible for exactly one cycle
    out_ready = 1'b1;
    send(4'd3, 4'd5, 3'b000);
    chk("sub_c", c, 4'hE);
    chk("sub_ovf", ovf, 1);
    chk("sub_zero", zero, 0);
    chk("sub_valid", out_valid, 1);
    tick();
    chk("sub_one_cycle", out_valid, 0);

    // add with carry, then a zero difference
    send(4'd9, 4'd8, 3'b001);
    chk("add_c", c, 4'h1);
    chk("add_ovf", ovf, 1);
    tick();
    send(4'd8, 4'd8, 3'b000);
    chk("sub0_c", c, 0);
    chk("sub0_zero", zero, 1);
    chk("sub0_ovf", ovf, 0);
    tick();

    // multiply latency, then backpressure
    out_ready = 1'b0;
    send(4'd7, 4'd3, 3'b010);
    chk("mul_accept_ready", in_ready, 0);
    for (int i = 1; i <= W; i++) begin
      tick();
      chk("mul_busy_ready", in_ready, 0);
      chk("mul_busy_valid", out_valid, 0);
    end
    tick();
    chk("mul_valid", out_valid, 1);
    chk("mul_c", c, 4'h5);
    chk("mul_ovf", ovf, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 4'd1; b = 4'd1; modo = 3'b001;
      tick();
      chk("bp_c", c, 4'h5);
      chk("bp_ovf", ovf, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    // reset in the middle of a multiply
    send(4'd5, 4'd6, 3'b010);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_c", c, 0);
    chk("mrst_flags", {ovf, zero, err, out_valid}, 0);
    chk("mrst_ready", in_ready, 1);
    send(4'd2, 4'd2, 3'b001);
    chk("mrst_add_c", c, 4'h4);
    tick();

    // divide
    send(4'd13, 4'd4, 3'b111);
`ifdef CALC_DIV_EN
    for (int i = 1; i <= W; i++) begin
      tick();
      chk("div_busy_valid", out_valid, 0);
    end
    tick();
    chk("div_valid", out_valid, 1);
    chk("div_c", c, 4'h3);
    chk("div_ovf", ovf, 0);
    chk("div_err", err, 0);
    tick();
    send(4'd13, 4'd0, 3'b111);
    chk("div0_wait", out_valid, 0);
    tick();
    chk("div0_valid", out_valid, 1);
    chk("div0_c", c, 4'hF);
    chk("div0_ovf", ovf, 1);
    tick();
`else
    chk("div_valid", out_valid, 1);
    chk("div_c", c, 0);
    chk("div_err", err, 1);
    chk("div_zero", zero, 1);
    chk("div_ovf", ovf, 0);
    tick();
`endif

    // randomized traffic with random backpressure and occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom_range(0, MOD - 1));
      modo      = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq_alu.md
CALC_SEQ_ALU -- requirements
Module: calc_seq_alu

Interface
REQ-001 Parameter line SHALL read: W, 4, operand and result width in bits (W >= 2).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid SHALL be: in_valid  input  1  operands/mode presented.
REQ-005 Port in_ready SHALL be: in_ready  output  1  block can accept an operation.
REQ-006 Port a SHALL be: a  input  W  operand A, unsigned.
REQ-007 Port b SHALL be: b  input  W  operand B, unsigned.
REQ-008 Port modo SHALL be: modo  input  3  operation select.
REQ-009 Port c SHALL be: c  output  W  registered result.
REQ-010 Port ovf SHALL be: ovf  output  1  carry/borrow/overflow/divide-by-zero flag.
REQ-011 Port zero SHALL be: zero  output  1  high when c == 0.
REQ-012 Port err SHALL be: err  output  1  unsupported mode flag.
REQ-013 Port out_valid SHALL be: out_valid  output  1  c/ovf/zero/err valid.
REQ-014 Port out_ready SHALL be: out_ready  input  1  consumer accepts the result.

Function
REQ-015 Modes SHALL be:
- 000: a-b mod 2^W; ovf = (a<b).
- 001: a+b mod 2^W; ovf = carry out.
- 010: a*b, low W bits; ovf = (high W bits != 0).
- 011: c=0.
- 100: a&b.
- 101: a|b.
- 110: a^b.
- 111: divide (see Configuration).
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an operation SHALL be accepted on an edge where in_valid && in_ready.
REQ-018 For single-cycle modes (000, 001, 011-110), accept at edge N SHALL load results and enter DONE, so out_valid=1 after edge N.
REQ-019 Mode 010 SHALL enter MUL and perform shift-add for exactly W cycles using a counter; results SHALL load and DONE SHALL be entered so out_valid=1 after edge N+W+1.
REQ-020 Operands and mode SHALL be captured at accept; later changes on a/b/modo SHALL NOT affect the operation in progress.
REQ-021 In DONE, out_valid=1 and c/ovf/zero/err SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-022 out_valid and in_ready SHALL never both be 1; no new accept SHALL occur in the DONE cycle that is released.
REQ-023 zero SHALL be computed from the loaded c value; ovf and err SHALL be 0 for modes 011-110.
REQ-024 c and all flags SHALL retain their last loaded values while in IDLE/MUL/DIV (out_valid=0).

Reset
REQ-025 On an edge with rst=1 the block SHALL enter IDLE with c=0, ovf=0, zero=0, err=0, out_valid=0, and the counter and internal registers cleared; rst SHALL take priority over every other event.
REQ-026 rst asserted during MUL, DIV, or DONE SHALL abandon the operation with no result produced; in_ready=1 SHALL hold on the first cycle after rst deasserts.

Configuration
REQ-027 With macro CALC_DIV_EN defined, mode 111 SHALL perform restoring unsigned division a/b in state DIV for W cycles:
- c = quotient, ovf=0, err=0.
- out_valid at the same latency as MUL.
- If b=0: c = all ones, ovf=1, and DONE is entered at edge N+1.
REQ-028 Without CALC_DIV_EN, mode 111 SHALL behave as single-cycle: c=0, err=1, ovf=0, zero=1; no DIV state or divider logic SHALL be present.

Verification (W=4)
REQ-029 Subtract: a=3, b=5, modo=000, out_ready=1 -> next cycle c=0xE, ovf=1, zero=0, out_valid=1 for one cycle.
REQ-030 Add: a=9, b=8, modo=001 -> c=0x1, ovf=1, then a=8, b=8, modo=000 -> c=0, zero=1, ovf=0.
REQ-031 Multiply: a=7, b=3, modo=010 accepted at edge N -> in_ready=0 through MUL, out_valid after edge N+5, c=0x5, ovf=1.
REQ-032 Backpressure: out_ready=0 for 3 cycles after result -> c/flags stable, in_ready=0 and in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 Reset: rst=1 for one cycle mid-MUL (counter=2) -> next cycle all outputs 0, in_ready=1; a fresh add a=2, b=2 -> c=4.
REQ-034 Divide: modo=111, a=13, b=4 -> with CALC_DIV_EN c=3 at MUL latency; b=0 -> c=0xF, ovf=1; without CALC_DIV_EN -> c=0, err=1.
